seg_scan4: RTL and testbench
============================

SEG_SCAN4 -- requirements
Module: seg_scan4

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, cycles at the start of each slot with all anodes off; legal range 0 .. DIGIT_CYCLES-1.
REQ-003 SHALL have port clk, input, 1, the only clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port value, input, 16, four hex nibbles; value[3:0] is digit 0 (rightmost).
REQ-006 SHALL have port dp, input, 4, decimal point per digit, active-high.
REQ-007 SHALL have port en, input, 4, digit enable per digit, active-high.
REQ-008 SHALL have port load, input, 1, single-cycle request to capture value/dp/en.
REQ-009 SHALL have port load_ack, output, 1, one-cycle pulse when a captured request is applied to the display.
REQ-010 SHALL have port frame_start, output, 1, one-cycle pulse at each digit 3 -> digit 0 transition.
REQ-011 SHALL have port an, output, 4, anodes, active-low; an[i] drives digit i.
REQ-012 SHALL have port seg, output, 7, segments {a,b,c,d,e,f,g} on seg[6:0], active-low.
REQ-013 SHALL have port dp_n, output, 1, decimal point, active-low.

Function
REQ-014 SHALL run a slot counter 0..DIGIT_CYCLES-1 and a 2-bit digit index that increments, wrapping 3 -> 0, when the counter is at DIGIT_CYCLES-1.
REQ-015 SHALL, within each slot, stay in state BLANK while counter < BLANK_CYCLES and in state ON otherwise; with BLANK_CYCLES = 0, BLANK is never entered.
REQ-016 SHALL, in BLANK, drive an = 4'hF, seg = 7'h7F and dp_n = 1.
REQ-017 SHALL, in ON, drive an with only bit [digit] low if shown_en[digit] = 1, else 4'hF; seg = bitwise inverse of the hex pattern of shown_val nibble [digit]; dp_n = ~shown_dp[digit].
REQ-018 SHALL use active-high hex patterns 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, B=1F, C=4E, D=3D, E=4F, F=47.
REQ-019 SHALL register an, seg and dp_n, so they reflect the counter/digit/shown state one cycle later.
REQ-020 SHALL, on load = 1, copy value/dp/en into a pending register and set pending; a later load before adoption overwrites the pending register (latest wins).
REQ-021 SHALL, in the cycle after counter = DIGIT_CYCLES-1 with digit = 3 (frame boundary), pulse frame_start; if pending was set before that cycle, copy pending into shown_val/shown_dp/shown_en, clear pending and pulse load_ack in the same cycle.
REQ-022 SHALL, when load coincides with the frame-boundary cycle, adopt the previously pending contents (if any) and keep the new load as pending for the next frame.
REQ-023 SHALL never change the displayed contents except at a frame boundary, so no frame mixes two loaded values.

Reset
REQ-024 SHALL, on rst = 1 at a clock edge, set counter = 0, digit = 0, pending = 0, shown_val = 0, shown_dp = 0, shown_en = 0, an = 4'hF, seg = 7'h7F, dp_n = 1, load_ack = 0 and frame_start = 0.
REQ-025 SHALL give rst priority over load; a request pending or arriving during reset is discarded and produces no load_ack.
REQ-026 SHALL keep the display dark after reset until the first load is adopted, because shown_en = 0.

Structure
REQ-027 SHALL place in shared package seg_pkg: NUM_DIGITS = 4, the 16-entry hex pattern constant, and the active-low OFF constants (anodes 4'hF, segments 7'h7F).
REQ-028 SHALL instantiate one sub-module, seg_hex_decode, a combinational nibble -> active-high 7-bit pattern using the seg_pkg table; all inversion and registering stays in seg_scan4.

Verification (DIGIT_CYCLES = 8, BLANK_CYCLES = 2)
REQ-029 SHALL cover reset: rst high for 3 cycles with load = 1 -> an = F, seg = 7F, dp_n = 1 and load_ack = 0 throughout, with no later load_ack.
REQ-030 SHALL cover basic load: load value = 16'h12AF, en = F, dp = 4'b0001 -> load_ack at the first boundary; digit 0 slot shows an = E, seg = ~47 = 38, dp_n = 0; digit 3 shows seg = ~30 = 4F.
REQ-031 SHALL cover blanking: in every slot, an = F for exactly 2 cycles (offset by one cycle of output latency), then active for 6 cycles; frame_start period = 32 cycles.
REQ-032 SHALL cover latest-wins and simultaneous load: load 16'h1111, then 16'h2222 mid-frame, then 16'h3333 on the boundary cycle -> 2222 is adopted at this boundary and 3333 at the next, each with one load_ack.
REQ-033 SHALL cover disabled digits and mid-operation reset: en = 4'b0101 -> an[1] and an[3] stay 1; rst asserted mid-slot -> outputs return to their REQ-024 values on the next cycle and the display stays dark until the next load is adopted.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants and types for the seg_scan4 display scanner.
//   NUM_DIGITS : number of multiplexed digits
//   AN_OFF     : active-low anode pattern with every digit off
//   SEG_OFF    : active-low segment pattern with every segment off
//   HEX_TABLE  : active-high {a,b,c,d,e,f,g} pattern per hex nibble
//   phase_e    : position inside a digit slot (blanking or lit)
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index 15 is leftmost, so entry n is the pattern for nibble n.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_e;

  // Active-low anode vector selecting a single digit.
  function automatic logic [3:0] anode_select_n(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/seg_scan4_if.sv
// seg_scan4_if -- load channel of the display scanner.
//   value    : four hex nibbles, value[3:0] is the rightmost digit
//   dp       : decimal point per digit, active-high
//   en       : digit enable per digit, active-high
//   load     : single-cycle request to capture value/dp/en
//   load_ack : one-cycle pulse when a captured request reaches the display
// master drives the request, slave is the scanner.
interface seg_scan4_if;
  import seg_pkg::*;

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   en;
  logic                    load;
  logic                    load_ack;

  modport master (
    output value, dp, en, load,
    input  load_ack
  );

  modport slave (
    input  value, dp, en, load,
    output load_ack
  );

endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode -- combinational hex nibble to active-high 7-segment pattern.
//   nibble  : 4-bit hex digit
//   pattern : {a,b,c,d,e,f,g}, active-high
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Table lookup; every nibble value has an entry.
  always_comb begin
    pattern = HEX_TABLE[nibble];
  end

endmodule

// File: rtl/seg_scan4.sv
// seg_scan4 -- four-digit multiplexed 7-segment scanner with frame-aligned
// content updates.
//   clk, rst    : single rising-edge clock, synchronous active-high reset
//   bus         : load channel (value/dp/en/load in, load_ack out)
//   frame_start : one-cycle pulse when the scan wraps digit 3 -> digit 0
//   an          : anodes, active-low, an[i] drives digit i
//   seg         : segments {a..g} on seg[6:0], active-low
//   dp_n        : decimal point, active-low
// Loads are parked in a pending register and only copied into the shown
// register at a frame boundary, so one frame never mixes two loads.
module seg_scan4
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan4_if.slave  bus,
  output logic        frame_start,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0]           cnt_r;
  logic [1:0]              digit_r;
  logic                    pending_r;
  logic [4*NUM_DIGITS-1:0] pend_val_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic [NUM_DIGITS-1:0]   pend_en_r;
  logic [4*NUM_DIGITS-1:0] shown_val_r;
  logic [NUM_DIGITS-1:0]   shown_dp_r;
  logic [NUM_DIGITS-1:0]   shown_en_r;
  logic [3:0]              an_r;
  logic [6:0]              seg_r;
  logic                    dp_n_r;
  logic                    frame_start_r;
  logic                    load_ack_r;

  phase_e                  phase_s;
  logic [3:0]              nibble_s;
  logic [6:0]              pattern_s;
  logic                    slot_end_s;
  logic                    boundary_s;
  logic                    adopt_s;

  // Slot phase, digit nibble select and frame-boundary detection.
  always_comb begin
    phase_s    = PH_ON;
    nibble_s   = shown_val_r[3:0];
    slot_end_s = (cnt_r == CNT_LAST);
    boundary_s = slot_end_s && (digit_r == 2'd3);
    // Adoption uses the pending flag as it stood before this edge, so a load
    // arriving now stays pending for the following frame.
    adopt_s    = boundary_s && pending_r;
    if (cnt_r < CNT_BLANK) begin
      phase_s = PH_BLANK;
    end else begin
      phase_s = PH_ON;
    end
    case (digit_r)
      2'd0:    nibble_s = shown_val_r[3:0];
      2'd1:    nibble_s = shown_val_r[7:4];
      2'd2:    nibble_s = shown_val_r[11:8];
      2'd3:    nibble_s = shown_val_r[15:12];
      default: nibble_s = shown_val_r[3:0];
    endcase
  end

  seg_hex_decode u_decode (
    .nibble  (nibble_s),
    .pattern (pattern_s)
  );

  // Slot counter, digit index, pending capture and frame-boundary adoption.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r         <= {CW{1'b0}};
      digit_r       <= 2'd0;
      pending_r     <= 1'b0;
      pend_val_r    <= 16'h0000;
      pend_dp_r     <= 4'h0;
      pend_en_r     <= 4'h0;
      shown_val_r   <= 16'h0000;
      shown_dp_r    <= 4'h0;
      shown_en_r    <= 4'h0;
      frame_start_r <= 1'b0;
      load_ack_r    <= 1'b0;
    end else begin
      if (slot_end_s) begin
        cnt_r   <= {CW{1'b0}};
        digit_r <= digit_r + 2'd1;
      end else begin
        cnt_r   <= cnt_r + CW'(1);
      end
      frame_start_r <= boundary_s;
      load_ack_r    <= adopt_s;
      if (adopt_s) begin
        shown_val_r <= pend_val_r;
        shown_dp_r  <= pend_dp_r;
        shown_en_r  <= pend_en_r;
      end
      if (bus.load) begin
        pend_val_r <= bus.value;
        pend_dp_r  <= bus.dp;
        pend_en_r  <= bus.en;
        pending_r  <= 1'b1;
      end else if (adopt_s) begin
        pending_r  <= 1'b0;
      end
    end
  end

  // Registered display drive from the current slot state.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r   <= AN_OFF;
      seg_r  <= SEG_OFF;
      dp_n_r <= 1'b1;
    end else if (phase_s == PH_BLANK) begin
      an_r   <= AN_OFF;
      seg_r  <= SEG_OFF;
      dp_n_r <= 1'b1;
    end else begin
      an_r   <= shown_en_r[digit_r] ? anode_select_n(digit_r) : AN_OFF;
      seg_r  <= ~pattern_s;
      dp_n_r <= ~shown_dp_r[digit_r];
    end
  end

  assign an           = an_r;
  assign seg          = seg_r;
  assign dp_n         = dp_n_r;
  assign frame_start  = frame_start_r;
  assign bus.load_ack = load_ack_r;

endmodule

// File: tb/tb_seg_scan4.sv
// tb_seg_scan4 -- self-checking bench for seg_scan4 with DIGIT_CYCLES = 8 and
// BLANK_CYCLES = 2. The reference model derives slot position and digit from
// the number of clock edges since reset and applies the load/adopt rules on
// plain variables.
module tb_seg_scan4;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * DC;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp_n;

  seg_scan4_if bus ();

  seg_scan4 #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .frame_start (frame_start),
    .an          (an),
    .seg         (seg),
    .dp_n        (dp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference state
  int          m_t;
  logic        m_pend;
  logic [15:0] m_pval, m_sval;
  logic [3:0]  m_pdp, m_pen, m_sdp, m_sen;
  logic [13:0] exp_vec;
  logic [13:0] obs;
  assign obs = {an, seg, dp_n, frame_start, bus.load_ack};

  // One clock: drive inputs, update the model at the edge, return at negedge.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] d,
                       input logic [3:0] e, input logic r);
    int pos, dig;
    logic bnd, ack;
    logic [3:0] a;
    logic [6:0] s;
    logic p;
    rst = r;
    bus.load = ld;
    bus.value = v;
    bus.dp = d;
    bus.en = e;
    @(posedge clk);
    if (r) begin
      m_t = 0; m_pend = 1'b0; m_sval = 16'h0; m_sdp = 4'h0; m_sen = 4'h0;
      exp_vec = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
    end else begin
      pos = m_t % DC;
      dig = (m_t / DC) % 4;
      bnd = (pos == DC - 1) && (dig == 3);
      ack = bnd && m_pend;
      if (pos < BC) begin
        a = 4'hF; s = 7'h7F; p = 1'b1;
      end else begin
        a = m_sen[dig] ? ~(4'b0001 << dig) : 4'hF;
        s = ~hex_tab[m_sval[dig*4 +: 4]];
        p = ~m_sdp[dig];
      end
      exp_vec = {a, s, p, bnd, ack};
      if (ack) begin
        m_sval = m_pval; m_sdp = m_pdp; m_sen = m_pen; m_pend = 1'b0;
      end
      if (ld) begin
        m_pval = v; m_pdp = d; m_pen = e; m_pend = 1'b1;
      end
      m_t++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int acks, lit;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'($urandom), 4'($urandom), 4'hF, 1'b1);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL reset_model act=%h exp=%h", obs, exp_vec);
      end
      checks++;
      if ({an, seg, dp_n, bus.load_ack} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++; $display("FAIL reset_values act=%h exp=%h", {an, seg, dp_n, bus.load_ack},
                           {4'hF, 7'h7F, 1'b1, 1'b0});
      end
    end
    acks = 0; lit = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL reset_idle act=%h exp=%h", obs, exp_vec);
      end
      if (bus.load_ack === 1'b1) acks++;
      if (an !== 4'hF) lit++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL reset_no_ack act=%0d exp=0", acks);
    end
    checks++;
    if (lit !== 0) begin
      errors++; $display("FAIL reset_dark act=%0d exp=0", lit);
    end
  endtask

  task automatic test_basic_load();
    logic seen;
    cycle(1'b1, 16'h12AF, 4'b0001, 4'hF, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL basic_model act=%h exp=%h", obs, exp_vec);
      end
      if (bus.load_ack === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL basic_ack_timeout act=0 exp=1");
    end
    for (int i = 0; i < 27; i++) begin
      cycle(1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL basic_scan act=%h exp=%h", obs, exp_vec);
      end
      if (i == 2) begin
        checks++;
        if ({an, seg, dp_n} !== {4'hE, 7'h38, 1'b0}) begin
          errors++; $display("FAIL basic_digit0 act=%h exp=%h", {an, seg, dp_n}, {4'hE, 7'h38, 1'b0});
        end
      end
    end
    checks++;
    if ({an, seg, dp_n} !== {4'h7, 7'h4F, 1'b1}) begin
      errors++; $display("FAIL basic_digit3 act=%h exp=%h", {an, seg, dp_n}, {4'h7, 7'h4F, 1'b1});
    end
  endtask

  task automatic test_blanking();
    int fs_first, fs_count;
    while (m_t % FRAME != 0) begin
      cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL blank_align act=%h exp=%h", obs, exp_vec);
      end
    end
    fs_first = -1; fs_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL blank_model act=%h exp=%h", obs, exp_vec);
      end
      checks++;
      if ((an === 4'hF) !== ((i % DC) < BC)) begin
        errors++; $display("FAIL blank_window act=%h exp_dark=%0d", an, (i % DC) < BC);
      end
      if (frame_start === 1'b1) begin
        if (fs_count == 1) begin
          checks++;
          if (i - fs_first !== FRAME) begin
            errors++; $display("FAIL blank_fs_period act=%0d exp=%0d", i - fs_first, FRAME);
          end
        end
        if (fs_count == 0) fs_first = i;
        fs_count++;
      end
    end
    checks++;
    if (fs_count !== 2) begin
      errors++; $display("FAIL blank_fs_count act=%0d exp=2", fs_count);
    end
  endtask

  task automatic test_latest_wins();
    int acks;
    while (m_t % FRAME != 2) cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    cycle(1'b1, 16'h1111, 4'h0, 4'hF, 1'b0);
    while (m_t % FRAME != 16) cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    cycle(1'b1, 16'h2222, 4'h0, 4'hF, 1'b0);
    while (m_t % FRAME != FRAME - 1) begin
      cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL latest_pre act=%h exp=%h", obs, exp_vec);
      end
    end
    cycle(1'b1, 16'h3333, 4'h0, 4'hF, 1'b0);
    checks++;
    if (bus.load_ack !== 1'b1 || frame_start !== 1'b1) begin
      errors++; $display("FAIL latest_first_ack act=%b%b exp=11", bus.load_ack, frame_start);
    end
    acks = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL latest_model act=%h exp=%h", obs, exp_vec);
      end
      if (bus.load_ack === 1'b1) acks++;
      if (i == 2) begin
        checks++;
        if (seg !== 7'h12) begin
          errors++; $display("FAIL latest_2222 act=%h exp=12", seg);
        end
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++; $display("FAIL latest_second_ack act=%0d exp=1", acks);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    checks++;
    if (seg !== 7'h06) begin
      errors++; $display("FAIL latest_3333 act=%h exp=06", seg);
    end
  endtask

  task automatic test_disabled_and_reset();
    logic seen;
    int acks, lit;
    cycle(1'b1, 16'($urandom), 4'($urandom), 4'b0101, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      if (bus.load_ack === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL dis_ack_timeout act=0 exp=1");
    end
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL dis_model act=%h exp=%h", obs, exp_vec);
      end
      checks++;
      if (an[1] !== 1'b1 || an[3] !== 1'b1) begin
        errors++; $display("FAIL dis_anodes act=%b exp=1x1x", an);
      end
    end
    cycle(1'b1, 16'hBEEF, 4'hF, 4'hF, 1'b0);
    while (m_t % DC != 4) cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    cycle(1'b1, 16'hCAFE, 4'hF, 4'hF, 1'b1);
    checks++;
    if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midreset_values act=%h exp=%h", obs, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    end
    acks = 0;
    for (int i = 0; i < 2 * FRAME + 6; i++) begin
      cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL midreset_model act=%h exp=%h", obs, exp_vec);
      end
      if (bus.load_ack === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL midreset_no_ack act=%0d exp=0", acks);
    end
    cycle(1'b1, 16'h0008, 4'h0, 4'b0001, 1'b0);
    lit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL relight_model act=%h exp=%h", obs, exp_vec);
      end
      if (an === 4'hE && seg === 7'h00) lit++;
    end
    checks++;
    if (lit === 0) begin
      errors++; $display("FAIL relight_lit act=%0d exp=>0", lit);
    end
  endtask

  task automatic test_random();
    logic ld, r;
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 249) == 0);
      cycle(ld, 16'($urandom), 4'($urandom), 4'($urandom), r);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL random act=%h exp=%h cyc=%0d", obs, exp_vec, i);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b0;
    bus.value = 16'h0;
    bus.dp = 4'h0;
    bus.en = 4'h0;
    m_t = 0; m_pend = 1'b0;
    m_pval = 16'h0; m_pdp = 4'h0; m_pen = 4'h0;
    m_sval = 16'h0; m_sdp = 4'h0; m_sen = 4'h0;
    exp_vec = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
    test_reset();
    test_basic_load();
    test_blanking();
    test_latest_wins();
    test_disabled_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
